// File: rtl/dp_trace_buffer_if.sv
// dp_trace_buffer_if: 32-bit valid/ready dump port of the trace buffer.
// master drives the words out, slave is the consumer.
interface dp_trace_buffer_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/dp_trace_buffer.sv
// dp_trace_buffer: circular capture of {pc,inst,alu} per cycle,
// frozen after a PC/forced trigger and drained oldest-first.
module dp_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [31:0]           trig_pc,
  input  logic                  force_trig,
  input  logic [31:0]           pc,
  input  logic [31:0]           inst,
  input  logic [31:0]           alu,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   count,
  dp_trace_buffer_if.master     rd
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LD = CW'(POST_COUNT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] P1 = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } st_t;

  st_t st;
  logic [95:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_nxt, ptr_n, done_ptr;
  logic [CW-1:0] cnt_inc, cnt_n, post_cnt;
  logic [1:0] idx, idx_n;
  logic wr_en, hit, xfer;

  function automatic logic [31:0] pick(
    input logic [95:0] e,
    input logic [1:0]  i
  );
    case (i)
      2'd0:    return e[95:64];
      2'd1:    return e[63:32];
      default: return e[31:0];
    endcase
  endfunction

  assign state = st;

  always_comb begin
    wr_en = (st == PRE) || (st == POST);
    wr_nxt = wr_ptr + P1;
    cnt_inc = (count == FULL) ? count : count + ONE;
    // oldest entry, computed from post-write pointer and count
    done_ptr = wr_nxt - cnt_inc[DEPTH_LOG2-1:0];
    hit = (trig_en && (pc == trig_pc)) || force_trig;
    xfer = rd.valid && rd.ready;
    idx_n = idx + 2'd1;
    ptr_n = rd_ptr;
    cnt_n = count;
    if (idx == 2'd2) begin
      idx_n = 2'd0;
      ptr_n = rd_ptr + P1;
      cnt_n = count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pc, inst, alu};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      idx      <= '0;
      rd.valid <= 1'b0;
      rd.data  <= '0;
      rd.last  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (arm) begin
            st     <= PRE;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        PRE: begin
          wr_ptr <= wr_nxt;
          count  <= cnt_inc;
          if (hit) begin
            if (POST_COUNT == 1) begin
              st     <= DONE;
              rd_ptr <= done_ptr;
              idx    <= '0;
            end else begin
              st       <= POST;
              post_cnt <= POST_LD;
            end
          end
        end
        POST: begin
          wr_ptr   <= wr_nxt;
          count    <= cnt_inc;
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) begin
            st     <= DONE;
            rd_ptr <= done_ptr;
            idx    <= '0;
          end
        end
        DONE: begin
          if (arm) begin
            st       <= PRE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= '0;
            rd.valid <= 1'b0;
            rd.data  <= '0;
            rd.last  <= 1'b0;
          end else if (!rd.valid) begin
            rd.valid <= 1'b1;
            rd.data  <= pick(mem[rd_ptr], idx);
            rd.last  <= (count == ONE) && (idx == 2'd2);
          end else if (xfer) begin
            idx    <= idx_n;
            rd_ptr <= ptr_n;
            count  <= cnt_n;
            if (rd.last) begin
              st       <= IDLE;
              rd.valid <= 1'b0;
              rd.data  <= '0;
              rd.last  <= 1'b0;
            end else begin
              rd.data <= pick(mem[ptr_n], idx_n);
              rd.last <= (cnt_n == ONE) && (idx_n == 2'd2);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dp_trace_buffer.sv
// tb_dp_trace_buffer: randomized captures and dumps checked
// against a sample-history model of the trace buffer.
module tb_dp_trace_buffer;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int POST = 8;

  logic        clk;
  logic        clr;
  logic        arm;
  logic        trig_en;
  logic        force_trig;
  logic [31:0] trig_pc;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] alu;
  logic [1:0]  state;
  logic [DL:0] count;

  dp_trace_buffer_if rd_if ();

  dp_trace_buffer #(
    .DEPTH_LOG2(DL),
    .POST_COUNT(POST)
  ) dut (
    .clk(clk),
    .clr(clr),
    .arm(arm),
    .trig_en(trig_en),
    .trig_pc(trig_pc),
    .force_trig(force_trig),
    .pc(pc),
    .inst(inst),
    .alu(alu),
    .state(state),
    .count(count),
    .rd(rd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] hist[$];
  int ents;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input int exp_st);
    chk({tag, "_state"}, state, exp_st);
    chk({tag, "_valid"}, rd_if.valid, 0);
    chk({tag, "_data"}, rd_if.data, 0);
    chk({tag, "_last"}, rd_if.last, 0);
  endtask

  // arm, then drive t pre-trigger samples plus POST samples;
  // mode 0 = pc match, mode 1 = force_trig with a disabled pc decoy
  task automatic capture(input logic [31:0] base, input int t,
                         input int mode, input logic rdy);
    int n;
    int exp_st;
    n = t + POST;
    hist.delete();
    arm = 1'b1;
    rd_if.ready = rdy;
    step();
    arm = 1'b0;
    rd_if.ready = 1'b0;
    chk_quiet("arm", 1);
    chk("arm_count", count, 0);
    trig_pc = (mode == 0) ? base + 32'(4 * t) : base + 32'(4 * (t / 2));
    for (int k = 0; k < n; k++) begin
      pc = base + 32'(4 * k);
      inst = $urandom;
      alu = $urandom;
      if (k <= t) begin
        trig_en = (mode == 0);
        force_trig = (mode == 1) && (k == t);
      end else begin
        trig_en = 1'($urandom % 2);
        force_trig = 1'($urandom % 2);
      end
      arm = (k > 0) && ($urandom % 4 == 0);
      hist.push_back(pc);
      hist.push_back(inst);
      hist.push_back(alu);
      step();
      if (k == n - 1) exp_st = 3;
      else if (k < t) exp_st = 1;
      else exp_st = 2;
      chk("cap_state", state, exp_st);
      chk("cap_count", count, (k + 1 < DEPTH) ? k + 1 : DEPTH);
    end
    arm = 1'b0;
    trig_en = 1'b0;
    force_trig = 1'b0;
    ents = (n < DEPTH) ? n : DEPTH;
    chk("valid_at_done", rd_if.valid, 0);
  endtask

  // mode 0 = always ready, 1 = random, 2 = toggle with a 5-cycle stall
  task automatic drain(input int mode, input int limit);
    int total;
    int first;
    int w;
    int c;
    logic r;
    logic stalled;
    logic [31:0] hd;
    logic hl;
    total = 3 * ents;
    first = hist.size() - total;
    w = 0;
    c = 0;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (w < limit && c < 2000) begin
      chk("rd_count", count, ents - w / 3);
      if (!rd_if.valid) chk("data_idle", rd_if.data, 0);
      if (stalled) begin
        chk("hold_data", rd_if.data, hd);
        chk("hold_last", rd_if.last, hl);
      end
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom % 3) != 0;
        default: r = (c >= 20 && c < 25) ? 1'b0 : c[0];
      endcase
      rd_if.ready = r;
      if (rd_if.valid && r) begin
        chk("word", rd_if.data, hist[first + w]);
        chk("last", rd_if.last, w == total - 1);
        w++;
      end
      stalled = rd_if.valid && !r;
      hd = rd_if.data;
      hl = rd_if.last;
      step();
      c++;
    end
    rd_if.ready = 1'b0;
    if (w < limit) chk("drain_timeout", w, limit);
    if (limit == total) begin
      chk_quiet("end", 0);
      chk("end_count", count, 0);
    end
  endtask

  initial begin
    clr = 1'b1;
    arm = 1'b0;
    trig_en = 1'b0;
    force_trig = 1'b0;
    trig_pc = '0;
    pc = '0;
    inst = '0;
    alu = '0;
    rd_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_quiet("reset", 0);
      chk("reset_count", count, 0);
    end
    clr = 1'b0;
    step();

    capture(32'h0, 16, 0, 1'b0);
    chk("wrap_count", count, 16);
    drain(0, 48);

    capture(32'h0, 0, 0, 1'b0);
    chk("early_count", count, 8);
    drain(0, 24);

    capture($urandom & ~32'h3, 5, 1, 1'b0);
    drain(1, 3 * ents);

    capture(32'h0, 16, 0, 1'b0);
    drain(2, 48);

    for (int i = 0; i < 6; i++) begin
      capture($urandom & ~32'h3, $urandom_range(0, 24),
              int'($urandom % 2), 1'b0);
      drain(1, 3 * ents);
    end

    capture($urandom & ~32'h3, 10, 0, 1'b0);
    drain(1, 7);
    capture($urandom & ~32'h3, 3, 1, 1'($urandom % 2));
    drain(1, 3 * ents);

    capture($urandom & ~32'h3, 12, 0, 1'b0);
    drain(1, 3 * ents - 1);
    chk("pre_arm_last", rd_if.last, 1);
    capture($urandom & ~32'h3, 2, 0, 1'b1);
    drain(1, 3 * ents);

    capture($urandom & ~32'h3, 20, 1, 1'b0);
    drain(1, 20);
    clr = 1'b1;
    #1;
    chk_quiet("clr_mid", 0);
    chk("clr_mid_count", count, 0);
    step();
    clr = 1'b0;
    step();
    capture($urandom & ~32'h3, 9, 0, 1'b0);
    drain(1, 3 * ents);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
